mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 154 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-to-writeback pipeline register.
// Extracts load data from the raw data-memory word in M, registers the
// writeback fields into W, selects the writeback result, and counts
// retired instructions.
// Optional feature: define MISALIGN_TRAP_EN to suppress register writes for
// misaligned loads and raise a sticky MisalignW flag. Without it, misaligned
// loads write normally using the lane-select rules and MisalignW is tied to 0.
module mem_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallW,
    input  logic        FlushW,
    input  logic        ValidM,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  rdM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] ReadDataM,
    input  logic [31:0] PCplus4M,
    output logic        ValidW,
    output logic        RegWriteW,
    output logic [4:0]  rdW,
    output logic [31:0] ResultW,
    output logic        MisalignW,
    output logic [31:0] RetireCount
);

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_LOAD = 2'b01,
        SRC_PC4  = 2'b10,
        SRC_ALU2 = 2'b11
    } result_src_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic        write_ok;

    logic        valid_w;
    logic        regwrite_w;
    logic [4:0]  rd_w;
    result_src_e resultsrc_w;
    logic [31:0] alu_w;
    logic [31:0] load_w;
    logic [31:0] pc4_w;
    logic [31:0] retire_count;

    // Byte lane picked by addr[1:0], half lane by addr[1]; lane 0 is the LSBs.
    assign load_byte = ReadDataM[{ALUResultM[1:0], 3'b000} +: 8];
    assign load_half = ReadDataM[{ALUResultM[1], 4'b0000} +: 16];

    // Format the load value according to the load width and signedness.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        load_data = ReadDataM;
        case (funct3M)
            F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            F3_LH:   load_data = {{16{load_half[15]}}, load_half};
            F3_LBU:  load_data = {24'h0, load_byte};
            F3_LHU:  load_data = {16'h0, load_half};
            default: load_data = ReadDataM;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_m;
    logic misalign_w;

    // Flag loads whose address is not aligned to the access width.
    always_comb begin
        misalign_m = 1'b0;
        if (ResultSrcM == SRC_LOAD) begin
            case (funct3M)
                F3_LH, F3_LHU: misalign_m = ALUResultM[0];
                F3_LW:         misalign_m = |ALUResultM[1:0];
                default:       misalign_m = 1'b0;
            endcase
        end
    end

    // x0 is never written, and a trapped misaligned load does not write either.
    assign write_ok = RegWriteM && (rdM != 5'd0) && !misalign_m;

    // Sticky misaligned-load flag, set only by a real (valid) captured load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_w <= 1'b0;
        end else if (!FlushW && !StallW && ValidM && misalign_m) begin
            misalign_w <= 1'b1;
        end
    end

    assign MisalignW = misalign_w;
`else
    // x0 is never written.
    assign write_ok  = RegWriteM && (rdM != 5'd0);
    assign MisalignW = 1'b0;
`endif

    // W pipeline register: flush inserts a bubble, stall holds, else capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_w      <= 1'b0;
            regwrite_w   <= 1'b0;
            rd_w         <= 5'd0;
            resultsrc_w  <= SRC_ALU;
            alu_w        <= 32'd0;
            load_w       <= 32'd0;
            pc4_w        <= 32'd0;
            retire_count <= 32'd0;
        end else if (FlushW) begin
            // NOTE: non-blocking assignments here so all W fields sample pre-edge values together.
            valid_w    <= 1'b0;
            regwrite_w <= 1'b0;
        end else if (!StallW) begin
            valid_w     <= ValidM;
            regwrite_w  <= write_ok;
            rd_w        <= rdM;
            resultsrc_w <= result_src_e'(ResultSrcM);
            alu_w       <= ALUResultM;
            load_w      <= load_data;
            pc4_w       <= PCplus4M;
            if (ValidM) begin
                retire_count <= retire_count + 32'd1;
            end
        end
    end

    // Writeback result mux driven from the W registers.
    always_comb begin
        ResultW = alu_w;
        case (resultsrc_w)
            SRC_LOAD: ResultW = load_w;
            SRC_PC4:  ResultW = pc4_w;
            default:  ResultW = alu_w;
        endcase
    end

    assign ValidW      = valid_w;
    assign RegWriteW   = regwrite_w;
    assign rdW         = rd_w;
    assign RetireCount = retire_count;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: self-checking bench for mem_wb_stage.
// A behavioural model tracks the expected W outputs; a compare process checks
// the DUT on every falling edge, and directed literal checks pin the model.
// Honors MISALIGN_TRAP_EN the same way the design does.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallW, FlushW, ValidM, RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  rdM;
    logic [31:0] ALUResultM, ReadDataM, PCplus4M;
    logic        ValidW, RegWriteW, MisalignW;
    logic [4:0]  rdW;
    logic [31:0] ResultW, RetireCount;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Model state: what the W outputs must show after each edge.
    bit          m_valid    = 1'b0;
    bit          m_regwrite = 1'b0;
    bit          m_misalign = 1'b0;
    bit          m_known    = 1'b1;
    logic [4:0]  m_rd       = 5'd0;
    logic [31:0] m_result   = 32'd0;
    logic [31:0] m_count    = 32'd0;

    mem_wb_stage dut (
        .clk        (clk),
        .reset      (reset),
        .StallW     (StallW),
        .FlushW     (FlushW),
        .ValidM     (ValidM),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .funct3M    (funct3M),
        .rdM        (rdM),
        .ALUResultM (ALUResultM),
        .ReadDataM  (ReadDataM),
        .PCplus4M   (PCplus4M),
        .ValidW     (ValidW),
        .RegWriteW  (RegWriteW),
        .rdW        (rdW),
        .ResultW    (ResultW),
        .MisalignW  (MisalignW),
        .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Load value from the word by shifting and masking, then sign-extending.
    function automatic logic [31:0] load_ref(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] addr);
        logic [31:0] b, h;
        b = (w >> (8 * (addr % 4))) & 32'hFF;
        h = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic bit mis_ref(input logic [1:0] src, input logic [2:0] f3, input logic [31:0] addr);
        if (src != 2'd1) return 1'b0;
        if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2) != 0) return 1'b1;
        if (f3 == 3'd2 && (addr % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction
`endif

    // Behavioural model of the stage, updated on the same events as the DUT.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid = 0; m_regwrite = 0; m_misalign = 0; m_known = 1;
            m_rd = 0; m_result = 0; m_count = 0;
        end else if (FlushW) begin
            m_valid = 0; m_regwrite = 0; m_known = 0;
        end else if (!StallW) begin
            m_valid    = ValidM;
            m_rd       = rdM;
            m_known    = 1;
            m_regwrite = RegWriteM && (rdM != 0);
            if (ResultSrcM == 2'd1)      m_result = load_ref(ReadDataM, funct3M, ALUResultM);
            else if (ResultSrcM == 2'd2) m_result = PCplus4M;
            else                         m_result = ALUResultM;
`ifdef MISALIGN_TRAP_EN
            if (mis_ref(ResultSrcM, funct3M, ALUResultM)) begin
                m_regwrite = 0;
                if (ValidM) m_misalign = 1;
            end
`endif
            if (ValidM) m_count = m_count + 1;
        end
    end

    // Compare process: DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ValidW", 32'(ValidW), 32'(m_valid));
            check("RegWriteW", 32'(RegWriteW), 32'(m_regwrite));
            check("MisalignW", 32'(MisalignW), 32'(m_misalign));
            check("RetireCount", RetireCount, m_count);
            if (m_known) begin
                check("rdW", 32'(rdW), 32'(m_rd));
                check("ResultW", ResultW, m_result);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit rw, input logic [1:0] src, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4);
        ValidM = v; RegWriteM = rw; ResultSrcM = src; funct3M = f3; rdM = rd;
        ALUResultM = alu; ReadDataM = rdata; PCplus4M = pc4;
    endtask

    task automatic rand_inputs();
        drive(($urandom % 8) != 0, 1'($urandom), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              5'($urandom), $urandom, $urandom, $urandom);
    endtask

    task automatic check_outputs(input string tag, input bit v, input bit rw, input logic [31:0] res,
                                 input bit mis, input logic [31:0] cnt);
        check({tag, ".ValidW"}, 32'(ValidW), 32'(v));
        check({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(rw));
        check({tag, ".ResultW"}, ResultW, res);
        check({tag, ".MisalignW"}, 32'(MisalignW), 32'(mis));
        check({tag, ".RetireCount"}, RetireCount, cnt);
    endtask

    initial begin
        reset = 1'b0; StallW = 1'b0; FlushW = 1'b0;
        drive(0, 0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        #12;
        check_outputs("reset", 0, 0, 32'd0, 0, 32'd0);
        check("reset.rdW", 32'(rdW), 32'd0);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Loads from 8899AABB.
        drive(1, 1, 2'd1, 3'b000, 5'd5, 32'h0000_0001, 32'h8899_AABB, 32'h0);
        step();
        check_outputs("lb", 1, 1, 32'hFFFF_FFAA, 0, 32'd1);
        check("lb.rdW", 32'(rdW), 32'd5);
        funct3M = 3'b100;
        step();
        check_outputs("lbu", 1, 1, 32'h0000_00AA, 0, 32'd2);
        funct3M = 3'b001; ALUResultM = 32'h0000_0002;
        step();
        check_outputs("lh", 1, 1, 32'hFFFF_8899, 0, 32'd3);

        // Stall for 3 cycles with changing inputs.
        StallW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step();
            check_outputs("stall", 1, 1, 32'hFFFF_8899, 0, 32'd3);
        end

        // Stall and flush together.
        FlushW = 1'b1; ValidM = 1'b1;
        step();
        check("flush.ValidW", 32'(ValidW), 32'd0);
        check("flush.RegWriteW", 32'(RegWriteW), 32'd0);
        check("flush.RetireCount", RetireCount, 32'd3);
        StallW = 1'b0; FlushW = 1'b0;

        // Result selection and x0.
        drive(1, 1, 2'd2, 3'd0, 5'd5, 32'h0, 32'h0, 32'h0000_0004);
        step();
        check_outputs("pc4", 1, 1, 32'h0000_0004, 0, 32'd4);
        drive(1, 1, 2'd0, 3'd0, 5'd5, 32'h0000_0010, 32'h0, 32'h0);
        step();
        check_outputs("alu", 1, 1, 32'h0000_0010, 0, 32'd5);
        rdM = 5'd0;
        step();
        check_outputs("x0", 1, 0, 32'h0000_0010, 0, 32'd6);

        // LW at a misaligned address, then an aligned LW.
        drive(1, 1, 2'd1, 3'b010, 5'd7, 32'h0000_0012, 32'h8899_AABB, 32'h0);
        step();
`ifdef MISALIGN_TRAP_EN
        check_outputs("lw_mis", 1, 0, 32'h8899_AABB, 1, 32'd7);
`else
        check_outputs("lw_mis", 1, 1, 32'h8899_AABB, 0, 32'd7);
`endif
        ALUResultM = 32'h0000_0010;
        step();
`ifdef MISALIGN_TRAP_EN
        check_outputs("lw_ok", 1, 1, 32'h8899_AABB, 1, 32'd8);
`else
        check_outputs("lw_ok", 1, 1, 32'h8899_AABB, 0, 32'd8);
`endif

        // Counter wrap from a preloaded value.
        #1;
        force dut.retire_count = 32'hFFFF_FFFE;
        m_count = 32'hFFFF_FFFE;
        #1;
        release dut.retire_count;
        ValidM = 1'b1;
        step();
        check("wrap1.RetireCount", RetireCount, 32'hFFFF_FFFF);
        step();
        check("wrap2.RetireCount", RetireCount, 32'h0000_0000);

        // Asynchronous reset mid-cycle while stalled.
        StallW = 1'b1;
        #3 reset = 1'b0;
        #1;
        check_outputs("async_rst", 0, 0, 32'd0, 0, 32'd0);
        check("async_rst.rdW", 32'(rdW), 32'd0);
        #2;
        reset = 1'b1; StallW = 1'b0;
        drive(1, 1, 2'd2, 3'd0, 5'd3, 32'h0, 32'h0, 32'h0000_0100);
        step();
        check_outputs("post_rst", 1, 1, 32'h0000_0100, 0, 32'd1);
        check("post_rst.rdW", 32'(rdW), 32'd3);

        // Randomized traffic with stalls, flushes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            StallW = ($urandom % 5) == 0;
            FlushW = ($urandom % 10) == 0;
            if (($urandom % 150) == 0) begin
                #3 reset = 1'b0;
                #3 reset = 1'b1;
            end
            step();
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
